mux_scan_sampler: RTL
=====================

MUX_SCAN_SAMPLER -- requirements
Module: mux_scan_sampler

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2, meaning clock cycles that sel is held before mux_o is captured (legal range 1..15).
REQ-002 SHALL have parameter WIDTH, default 16, meaning the data width of mux_o and sample.
REQ-003 SHALL use one clock; reset is synchronous and active-low.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 start  input  1  request one scan of the channels enabled in ch_mask.
REQ-007 ch_mask  input  4  channel enable, bit n = mux input n; sampled only when start is accepted.
REQ-008 mux_o  input  WIDTH  data from the downstream-fed 4:1 WIDTH-bit mux output.
REQ-009 sel  output  2  select driven to the mux s[1:0]; value n selects input n.
REQ-010 sample  output  WIDTH  captured mux_o word.
REQ-011 sample_ch  output  2  channel index of sample.
REQ-012 out_valid  output  1  sample/sample_ch valid.
REQ-013 out_ready  input  1  consumer accepts sample when out_valid and out_ready are both high.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 done  output  1  single-cycle pulse at scan end.

Function
REQ-016 SHALL implement FSM states IDLE, SETTLE, HOLD.
REQ-017 In IDLE, start=1 with ch_mask!=0 SHALL latch ch_mask, set sel to the lowest set bit, clear the settle counter, and move to SETTLE on the same edge.
REQ-018 In IDLE, start=1 with ch_mask==0 SHALL pulse done for one cycle and remain in IDLE.
REQ-019 SETTLE SHALL last exactly SETTLE_CYCLES cycles; on its final edge sample<=mux_o, sample_ch<=sel, out_valid<=1, and the state moves to HOLD.
REQ-020 Latency: start accepted at edge k gives out_valid=1 after edge k+SETTLE_CYCLES.
REQ-021 In HOLD, out_valid, sample and sample_ch SHALL remain stable until the handshake completes (out_valid & out_ready).
REQ-022 On handshake, if a higher set bit remains in the latched mask, sel SHALL step to the next higher set channel, out_valid SHALL clear, and the state SHALL return to SETTLE.
REQ-023 On handshake with no higher set bit, out_valid SHALL clear, done SHALL pulse for one cycle on the following cycle, sel SHALL return to 0, and the state SHALL return to IDLE.
REQ-024 sel SHALL change only on the edge entering SETTLE or IDLE, and never during SETTLE or HOLD.
REQ-025 start while busy=1 SHALL be ignored, with no effect on the latched mask or sequence.
REQ-026 Changes to ch_mask while busy SHALL be ignored.
REQ-027 out_ready=1 while out_valid=0 SHALL have no effect.
REQ-028 Channels SHALL be visited in ascending order only, with no wrap-around within a scan.
REQ-029 The next start SHALL be accepted from the cycle after the return to IDLE, including the done cycle.

Reset
REQ-030 rst_n=0 at a clock edge SHALL force IDLE, sel=0, sample=0, sample_ch=0, out_valid=0, busy=0, done=0, latched mask=0 and settle counter=0.
REQ-031 Reset mid-scan SHALL abort the scan with no done pulse; any pending sample SHALL be discarded.
REQ-032 Reset SHALL take priority over start and out_ready asserted in the same cycle.

Structure
REQ-033 A shared package SHALL hold the state enumeration (IDLE/SETTLE/HOLD), the channel count of 4, and the SETTLE_CYCLES default.
REQ-034 One sub-module next_ch_find SHALL be used: combinational, with inputs mask[3:0] and cur[1:0] plus a first flag, and outputs the next set channel index and found.
REQ-035 The block SHALL contain no mux datapath; it drives the existing 16-bit 4:1 mux via sel and consumes its output.

Verification
REQ-036 The bench SHALL instantiate the existing 16-bit 4:1 mux between the stimulus and the block, driving i0=6234, i1=725, i2=7524, i3=5734.
REQ-037 Scenario: start with ch_mask=4'b1111 and out_ready=1 -> samples 6234, 725, 7524, 5734 with sample_ch 0..3, each SETTLE_CYCLES+1 cycles apart, then one done pulse.
REQ-038 Scenario: ch_mask=4'b1010, out_ready held low 5 cycles on the first sample -> sample=725 held stable for 5 cycles, sel=1 held, then sample=5734 (ch 3), then done.
REQ-039 Scenario: start with ch_mask=0 -> done high for exactly 1 cycle, busy never high, out_valid never high.
REQ-040 Scenario: start re-pulsed while busy with a different mask -> sequence unchanged from the original mask.
REQ-041 Scenario: rst_n=0 for 1 cycle during HOLD of channel 2 -> all outputs 0 on the next cycle, no done pulse; a new start with ch_mask=4'b0100 then yields 7524.
REQ-042 Scenario: inputs changed to i0=65535, i3=9353, with ch_mask=4'b1001 -> samples 65535 then 9353, verifying the full-scale all-ones value.

Source files
------------

// File: rtl/mux_scan_sampler_pkg.sv
// Shared definitions for the mux scan sampler: channel count, select width,
// settle-counter sizing and the controller state encoding.
package mux_scan_sampler_pkg;

  localparam int NUM_CH            = 4;
  localparam int CH_W              = 2;
  localparam int SETTLE_CYCLES_DEF = 2;
  // Settle counter width; holds values up to 15 (the largest legal settle time).
  localparam int CNT_W             = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

endpackage

// File: rtl/mux_scan_sampler_next_ch.sv
// next_ch_find: picks the next enabled channel from a 4-bit mask.
// With first=1 it returns the lowest set bit. With first=0 it returns the
// lowest set bit strictly above cur, which gives an ascending scan that
// never wraps back to a lower channel.
module next_ch_find
  import mux_scan_sampler_pkg::*;
(
  input  logic [NUM_CH-1:0] mask,
  input  logic [CH_W-1:0]   cur,
  input  logic              first,
  output logic [CH_W-1:0]   next_ch,
  output logic              found
);

  // Walk from the top down so that the lowest qualifying channel wins.
  always_comb begin
    found   = 1'b0;
    next_ch = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i] && (first || (i > int'(cur)))) begin
        found   = 1'b1;
        next_ch = CH_W'(i);
      end
    end
  end

endmodule

// File: rtl/mux_scan_sampler.sv
// mux_scan_sampler: steps an external 4:1 mux through the enabled channels,
// waits for the mux output to settle, captures it, and hands each word to a
// valid/ready consumer. The block contains no mux datapath of its own; it only
// drives sel and samples mux_o.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | waiting for start; sel parked at 0
//   SETTLE | sel held on the current channel for SETTLE_CYCLES cycles
//   HOLD   | captured word presented on sample with out_valid high
module mux_scan_sampler
  import mux_scan_sampler_pkg::*;
#(
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
  parameter int WIDTH         = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic [WIDTH-1:0]  mux_o,
  output logic [CH_W-1:0]   sel,
  output logic [WIDTH-1:0]  sample,
  output logic [CH_W-1:0]   sample_ch,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  state_t              state_q, state_d;
  logic [NUM_CH-1:0]   mask_q, mask_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CH_W-1:0]     sel_q, sel_d;
  logic [WIDTH-1:0]    sample_q, sample_d;
  logic [CH_W-1:0]     sample_ch_q, sample_ch_d;
  logic                out_valid_q, out_valid_d;
  logic                done_q, done_d;

  logic [NUM_CH-1:0]   find_mask;
  logic                find_first;
  logic [CH_W-1:0]     find_ch;
  logic                find_ok;

  logic                handshake;

  // One channel finder is shared: in IDLE it looks at the live ch_mask for the
  // first channel, in HOLD it looks at the latched mask for the next one.
  next_ch_find u_next_ch_find (
    .mask    (find_mask),
    .cur     (sel_q),
    .first   (find_first),
    .next_ch (find_ch),
    .found   (find_ok)
  );

  assign handshake = out_valid_q && out_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath-update decode.
  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    cnt_d       = cnt_q;
    sel_d       = sel_q;
    sample_d    = sample_q;
    sample_ch_d = sample_ch_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;
    find_mask   = mask_q;
    find_first  = 1'b0;

    case (state_q)
      IDLE: begin
        find_mask  = ch_mask;
        find_first = 1'b1;
        if (start) begin
          if (find_ok) begin
            mask_d  = ch_mask;
            sel_d   = find_ch;
            cnt_d   = '0;
            state_d = SETTLE;
          end else begin
            // Empty mask: nothing to scan, report completion immediately.
            done_d = 1'b1;
          end
        end
      end

      SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          sample_d    = mux_o;
          sample_ch_d = sel_q;
          out_valid_d = 1'b1;
          state_d     = HOLD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      HOLD: begin
        if (handshake) begin
          out_valid_d = 1'b0;
          if (find_ok) begin
            sel_d   = find_ch;
            cnt_d   = '0;
            state_d = SETTLE;
          end else begin
            sel_d   = '0;
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d     = IDLE;
        sel_d       = '0;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // Datapath registers; reset discards any pending sample and suppresses done.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mask_q      <= '0;
      cnt_q       <= '0;
      sel_q       <= '0;
      sample_q    <= '0;
      sample_ch_q <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      mask_q      <= mask_d;
      cnt_q       <= cnt_d;
      sel_q       <= sel_d;
      sample_q    <= sample_d;
      sample_ch_q <= sample_ch_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
    end
  end

  assign sel       = sel_q;
  assign sample    = sample_q;
  assign sample_ch = sample_ch_q;
  assign out_valid = out_valid_q;
  assign done      = done_q;
  assign busy      = (state_q != IDLE);

endmodule
